// File: rtl/ps2_kbd_wb.sv
// ps2_kbd_wb
//   PS/2 keyboard receiver with a Wishbone slave register interface.
//   Frames arriving on PS2C/PS2D are deserialised in the bus clock domain.
//   Each good scancode is pushed into a small FIFO, and the CPU pops codes
//   through the DATA word. Framing errors and overflow are reported through
//   two sticky flags in the STAT word.
//
//   Optional feature macro: KBD_IRQ_EN
//     When defined, an irq output is added. It is a registered (count != 0).
//
// Ports
//   clk    in   1   system/bus clock
//   reset  in   1   synchronous active-high reset
//   PS2C   in   1   PS/2 clock (asynchronous)
//   PS2D   in   1   PS/2 data (asynchronous)
//   stb    in   1   Wishbone strobe
//   we     in   1   Wishbone write enable
//   addr   in   32  byte address; only addr[2] is decoded
//   dat_i  in   32  write data
//   dat_o  out  32  registered read data
//   ack    out  1   Wishbone acknowledge
//   irq    out  1   FIFO non-empty interrupt (KBD_IRQ_EN only)
//
// Register map (addr[2])
//   0 DATA  read : {23'b0, valid, code[7:0]}; pops one entry when non-empty
//   1 STAT  read : {19'b0, count[4:0], 6'b0, OVF, FERR}
//           write: bit0 clears FERR, bit1 clears OVF
//
// Bus FSM
//   state  | meaning
//   IDLE   | waiting for stb; on stb the access is performed and dat_o latched
//   ACK    | ack high for exactly one cycle
//   WAIT   | access done; hold here until the master drops stb
module ps2_kbd_wb #(
    parameter int FIFO_AW     = 4,
    parameter int TIMEOUT_CYC = 2500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PS2C,
    input  logic        PS2D,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack
`ifdef KBD_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]      TO_LOAD  = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0]      TO_ONE   = TW'(1);
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACK  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    // ------------------------------------------------------------------
    // Input synchronisers. They reset to idle-high so that a reset
    // cannot manufacture a falling edge.
    // ------------------------------------------------------------------
    logic [2:0] r_c_s;
    logic [2:0] r_d_s;
    logic       w_fall;
    logic       w_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_s <= 3'b111;
            r_d_s <= 3'b111;
        end else begin
            r_c_s <= {r_c_s[1:0], PS2C};
            r_d_s <= {r_d_s[1:0], PS2D};
        end
    end

    assign w_fall = r_c_s[2] & ~r_c_s[1];
    assign w_bit  = r_d_s[2];

    // ------------------------------------------------------------------
    // Frame capture. r_shift collects start, d0..d7 and parity, with the
    // newest bit at the top. The stop bit is taken live on the 11th fall.
    // ------------------------------------------------------------------
    logic [3:0]    r_bitcnt;
    logic [9:0]    r_shift;
    logic [TW-1:0] r_to;
    logic          w_frame_done;
    logic          w_frame_ok;
    logic          w_timeout;

    assign w_frame_done = w_fall && (r_bitcnt == 4'd10);
    assign w_frame_ok   = ~r_shift[0] & w_bit & (^r_shift[9:1]);
    assign w_timeout    = !w_fall && (r_bitcnt != 4'd0) && (r_to == TO_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitcnt <= 4'd0;
            r_shift  <= 10'd0;
            r_to     <= TO_LOAD;
        end else if (w_fall) begin
            r_shift  <= {w_bit, r_shift[9:1]};
            r_bitcnt <= w_frame_done ? 4'd0 : r_bitcnt + 4'd1;
            r_to     <= TO_LOAD;
        end else if (r_bitcnt != 4'd0) begin
            if (w_timeout) begin
                r_bitcnt <= 4'd0;
                r_to     <= TO_LOAD;
            end else begin
                r_to <= r_to - TO_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = w_frame_done & w_frame_ok & ~w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_shift[8:1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus access decode
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic        w_access;
    logic        w_sel_stat;
    logic        w_clr_ferr;
    logic        w_clr_ovf;
    logic        w_set_ferr;
    logic        w_set_ovf;
    logic        r_ferr;
    logic        r_ovf;
    logic [31:0] w_rd_data;

    // Only IDLE performs side effects, so a held strobe pops/clears once.
    assign w_access   = (r_state == S_IDLE) & stb;
    assign w_sel_stat = addr[2];
    assign w_pop      = w_access & ~we & ~w_sel_stat & ~w_empty;
    assign w_clr_ferr = w_access & we & w_sel_stat & dat_i[0];
    assign w_clr_ovf  = w_access & we & w_sel_stat & dat_i[1];
    assign w_set_ferr = (w_frame_done & ~w_frame_ok) | w_timeout;
    assign w_set_ovf  = w_frame_done & w_frame_ok & w_full;

    always_comb begin
        w_rd_data = 32'd0;
        if (w_sel_stat) begin
            w_rd_data = {19'd0, 5'(r_count), 6'd0, r_ovf, r_ferr};
        end else if (!w_empty) begin
            w_rd_data = {23'd0, 1'b1, r_mem[r_rptr]};
        end
    end

    // A set event in the same cycle as a clear keeps the flag high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_ferr <= (r_ferr & ~w_clr_ferr) | w_set_ferr;
            r_ovf  <= (r_ovf & ~w_clr_ovf) | w_set_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            ack     <= 1'b0;
            dat_o   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (stb) begin
                        if (!we) dat_o <= w_rd_data;
                        ack     <= 1'b1;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack     <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!stb) r_state <= S_IDLE;
                end
                default: begin
                    ack     <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef KBD_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk) begin
        if (reset) r_irq <= 1'b0;
        else       r_irq <= (r_count != '0);
    end

    assign irq = r_irq;
`endif

    // Address and data bits outside the decoded fields are intentionally ignored.
    logic w_unused_ok;
    assign w_unused_ok = ^{addr[31:3], addr[1:0], dat_i[31:2]};

endmodule

// File: tb/tb_ps2_kbd_wb.sv
module tb_ps2_kbd_wb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PS2C = 1'b1;
    logic        PS2D = 1'b1;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] dat_i = 32'd0;
    logic [31:0] dat_o;
    logic        ack;

    int n_pass = 0;
    int n_total = 0;

    localparam logic [31:0] A_DATA = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;

    ps2_kbd_wb dut (
        .clk   (clk),
        .reset (reset),
        .PS2C  (PS2C),
        .PS2D  (PS2D),
        .stb   (stb),
        .we    (we),
        .addr  (addr),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .ack   (ack)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        PS2D = b;
        wait_clk(4);
        PS2C = 1'b0;
        wait_clk(8);
        PS2C = 1'b1;
        wait_clk(4);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad);
        return {1'b1, (~^d) ^ bad, d, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic bad);
        logic [10:0] f;
        f = mk_frame(d, bad);
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        wait_clk(8);
    endtask

    // Single access: checks 1-clock latency and a one-cycle ack pulse.
    task automatic bus_acc(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] q);
        int lat;
        stb = 1'b1; we = w; addr = a; dat_i = d; lat = 0;
        do begin
            wait_clk(1);
            lat++;
        end while (!ack && lat < 20);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        q = dat_o;
        stb = 1'b0; we = 1'b0;
        wait_clk(1);
        check({tag, "_ackpulse"}, {31'd0, ack}, 32'd0);
        wait_clk(1);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] q;
        bus_acc(tag, 1'b0, a, 32'd0, q);
        check(tag, q, exp);
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus_acc(tag, 1'b1, a, d, q);
    endtask

    initial begin
        logic [10:0] f;
        logic [31:0] q;
        int acks;

        // Reset state
        wait_clk(3);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat_o", dat_o, 32'd0);
        reset = 1'b0;
        wait_clk(2);
        rd("rst_stat", A_STAT, 32'h0);
        rd("rst_data_empty", A_DATA, 32'h0);

        // 1. good frame 0x1C
        send_frame(8'h1C, 1'b0);
        rd("t1_stat_cnt1", A_STAT, 32'h0000_0100);
        rd("t1_data", A_DATA, 32'h0000_011C);
        rd("t1_stat_cnt0", A_STAT, 32'h0);

        // 2. bad parity
        send_frame(8'h1C, 1'b1);
        rd("t2_stat_ferr", A_STAT, 32'h0000_0001);
        rd("t2_data_empty", A_DATA, 32'h0);
        wr("t2_clr", A_STAT, 32'h1);
        rd("t2_stat_clr", A_STAT, 32'h0);

        // 3. overflow
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b0);
        rd("t3_stat_full", A_STAT, 32'h0000_1002);
        for (int i = 1; i <= 16; i++) rd("t3_data", A_DATA, 32'h100 | 32'(i));
        rd("t3_data_empty", A_DATA, 32'h0);
        wr("t3_data_wr", A_DATA, 32'hFF);
        rd("t3_stat_ovf", A_STAT, 32'h0000_0002);
        wr("t3_clr", A_STAT, 32'h2);
        rd("t3_stat_clr", A_STAT, 32'h0);

        // 4. timeout mid-frame
        f = mk_frame(8'hAA, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(f[i]);
        wait_clk(2600);
        rd("t4_stat_ferr", A_STAT, 32'h0000_0001);
        wr("t4_clr", A_STAT, 32'h1);
        send_frame(8'hF0, 1'b0);
        rd("t4_stat_after", A_STAT, 32'h0000_0100);
        rd("t4_data_f0", A_DATA, 32'h0000_01F0);

        // 5. held strobe: one ack, one pop
        send_frame(8'h22, 1'b0);
        send_frame(8'h33, 1'b0);
        stb = 1'b1; we = 1'b0; addr = A_DATA;
        acks = 0; q = 32'd0;
        for (int i = 0; i < 10; i++) begin
            wait_clk(1);
            if (ack) begin
                acks++;
                q = dat_o;
            end
        end
        stb = 1'b0;
        wait_clk(2);
        check("t5_acks", 32'(acks), 32'd1);
        check("t5_data", q, 32'h0000_0122);
        check("t5_hold", dat_o, 32'h0000_0122);
        rd("t5_stat_cnt1", A_STAT, 32'h0000_0100);
        rd("t5_data2", A_DATA, 32'h0000_0133);

        // 6. frame completion coincident with a pop at count=1
        send_frame(8'h44, 1'b0);
        f = mk_frame(8'h55, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        PS2D = f[10];
        wait_clk(4);
        PS2C = 1'b0;
        wait_clk(2);
        stb = 1'b1; we = 1'b0; addr = A_DATA;
        acks = 0;
        while (!ack && acks < 20) begin
            wait_clk(1);
            acks++;
        end
        check("t6_lat", 32'(acks), 32'd1);
        check("t6_pop", dat_o, 32'h0000_0144);
        stb = 1'b0;
        wait_clk(6);
        PS2C = 1'b1;
        wait_clk(8);
        rd("t6_stat_cnt1", A_STAT, 32'h0000_0100);
        rd("t6_head", A_DATA, 32'h0000_0155);

        // Reset mid-frame
        for (int i = 0; i < 5; i++) send_bit(f[i]);
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(1);
        check("t6_rst_dat_o", dat_o, 32'h0);
        send_frame(8'h5A, 1'b0);
        rd("t6_rst_stat", A_STAT, 32'h0000_0100);
        rd("t6_rst_data", A_DATA, 32'h0000_015A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
